// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between an instruction-fetch
// port (I, read-only) and a load/store port (D) using fixed 4-state accesses.
module mem_arbiter #(
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_mask,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]        r_state;
  logic              r_last_d;
  logic              r_grant_d;
  logic              r_i_done;
  logic [DW-1:0]     r_i_rdata;
  logic              r_d_done;
  logic [DW-1:0]     r_d_rdata;
  logic              r_mem_request;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic [BW-1:0]     r_mem_mask;

  logic [1:0]        w_state_nx;
  logic              w_last_d_nx;
  logic              w_grant_d_nx;
  logic              w_i_done_nx;
  logic [DW-1:0]     w_i_rdata_nx;
  logic              w_d_done_nx;
  logic [DW-1:0]     w_d_rdata_nx;
  logic              w_mem_request_nx;
  logic              w_mem_we_nx;
  logic [MEM_AW-1:0] w_mem_addr_nx;
  logic [DW-1:0]     w_mem_wdata_nx;
  logic [BW-1:0]     w_mem_mask_nx;
  logic              w_pick_d;
  logic              w_unused;

  // D wins when it is alone, or when both request and I was granted last.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  // Only the word-index bits of the addresses matter; mem_valid is not needed.
  assign w_unused = &{1'b0, i_addr, d_addr, mem_valid};

  always_comb begin
    w_state_nx       = r_state;
    w_last_d_nx      = r_last_d;
    w_grant_d_nx     = r_grant_d;
    w_i_done_nx      = 1'b0;
    w_i_rdata_nx     = r_i_rdata;
    w_d_done_nx      = 1'b0;
    w_d_rdata_nx     = r_d_rdata;
    w_mem_request_nx = 1'b0;
    w_mem_we_nx      = r_mem_we;
    w_mem_addr_nx    = r_mem_addr;
    w_mem_wdata_nx   = r_mem_wdata;
    w_mem_mask_nx    = r_mem_mask;
    case (r_state)
      S_IDLE: begin
        if (i_req | d_req) begin
          w_state_nx       = S_ISSUE;
          w_grant_d_nx     = w_pick_d;
          w_last_d_nx      = w_pick_d;
          w_mem_request_nx = 1'b1;
          if (w_pick_d) begin
            w_mem_we_nx    = d_we;
            w_mem_addr_nx  = d_addr[ADDR_LSB +: MEM_AW];
            w_mem_wdata_nx = d_wdata;
            w_mem_mask_nx  = d_mask;
          end else begin
            w_mem_we_nx    = 1'b0;
            w_mem_addr_nx  = i_addr[ADDR_LSB +: MEM_AW];
            w_mem_wdata_nx = '0;
            w_mem_mask_nx  = '1;
          end
        end
      end
      S_ISSUE: w_state_nx = S_CAPTURE;
      S_CAPTURE: begin
        // Read data arrives the cycle after the strobe; route it to the winner.
        w_state_nx = S_RESP;
        if (!r_mem_we) begin
          if (r_grant_d) w_d_rdata_nx = mem_data_out;
          else           w_i_rdata_nx = mem_data_out;
        end
        if (r_grant_d) w_d_done_nx = 1'b1;
        else           w_i_done_nx = 1'b1;
      end
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_last_d      <= 1'b1;
      r_grant_d     <= 1'b0;
      r_i_done      <= 1'b0;
      r_i_rdata     <= '0;
      r_d_done      <= 1'b0;
      r_d_rdata     <= '0;
      r_mem_request <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_mask    <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_last_d      <= w_last_d_nx;
      r_grant_d     <= w_grant_d_nx;
      r_i_done      <= w_i_done_nx;
      r_i_rdata     <= w_i_rdata_nx;
      r_d_done      <= w_d_done_nx;
      r_d_rdata     <= w_d_rdata_nx;
      r_mem_request <= w_mem_request_nx;
      r_mem_we      <= w_mem_we_nx;
      r_mem_addr    <= w_mem_addr_nx;
      r_mem_wdata   <= w_mem_wdata_nx;
      r_mem_mask    <= w_mem_mask_nx;
    end
  end

  assign i_done      = r_i_done;
  assign i_rdata     = r_i_rdata;
  assign d_done      = r_d_done;
  assign d_rdata     = r_d_rdata;
  assign mem_request = r_mem_request;
  assign mem_we_re   = r_mem_we;
  assign mem_address = r_mem_addr;
  assign mem_data_in = r_mem_wdata;
  assign mem_mask    = r_mem_mask;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter against a behavioural word memory and
// checks it against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int NCYC = 256;
  localparam int INF  = 1000000;
  localparam int MFW  = 45;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_mask;
  logic        i_done, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_request, mem_we_re, mem_valid;
  logic [AW-1:0] mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic [3:0]  mem_mask;

  mem_arbiter #(.MEM_AW(AW), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_valid(mem_valid),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with a bench-side preload port.
  logic [31:0] tb_mem [256];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;
  always @(posedge clk) begin
    if (pl_we) tb_mem[pl_idx] <= pl_data;
    else if (mem_request) begin
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) tb_mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
      end else begin
        mem_data_out <= tb_mem[mem_address];
      end
    end
    if (!rst) mem_valid <= 1'b0;
    else if (mem_request && !mem_we_re) mem_valid <= 1'b1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        we;
    int          gap;
  } tx_t;
  tx_t iq[$];
  tx_t dq[$];

  logic [31:0] ref_mem [256];
  bit          dr_ireq [NCYC];
  logic [31:0] dr_iaddr [NCYC];
  bit          dr_dreq [NCYC];
  logic        dr_dwe [NCYC];
  logic [31:0] dr_daddr [NCYC];
  logic [31:0] dr_dwdata [NCYC];
  logic [3:0]  dr_dmask [NCYC];
  bit          ex_idone [NCYC];
  bit          ex_ddone [NCYC];
  bit          ex_iss [NCYC];
  bit          ex_iupd [NCYC];
  bit          ex_dupd [NCYC];
  logic [31:0] ex_ival [NCYC];
  logic [31:0] ex_dval [NCYC];
  logic [MFW-1:0] ex_mf [NCYC];
  bit          ob_idone [NCYC];
  bit          ob_ddone [NCYC];
  bit          ob_mreq [NCYC];
  logic [31:0] ob_irdata [NCYC];
  logic [31:0] ob_drdata [NCYC];
  logic [MFW-1:0] ob_mf [NCYC];
  int          last_cycle;
  int          n_checks = 0;
  int          n_fail = 0;

  // Transaction-level model: the arbiter frees up every 4 cycles; among the
  // requests that have arrived by then, a lone one wins, else the port not
  // granted last. Produces per-cycle drive and expected-result tables.
  task automatic build_schedule();
    int free, ia, da, ii, di, g, arr;
    bit last_d, win_d;
    tx_t t;
    logic [7:0] idx;
    logic [31:0] rd;
    for (int c = 0; c < NCYC; c++) begin
      dr_ireq[c] = 0; dr_iaddr[c] = '0; dr_dreq[c] = 0; dr_dwe[c] = 1'b0;
      dr_daddr[c] = '0; dr_dwdata[c] = '0; dr_dmask[c] = '0;
      ex_idone[c] = 0; ex_ddone[c] = 0; ex_iss[c] = 0; ex_iupd[c] = 0; ex_dupd[c] = 0;
      ex_ival[c] = '0; ex_dval[c] = '0; ex_mf[c] = '0;
    end
    free = 0; last_d = 1'b1; ii = 0; di = 0; last_cycle = 0;
    ia = (iq.size() > 0) ? iq[0].gap : INF;
    da = (dq.size() > 0) ? dq[0].gap : INF;
    while (ii < iq.size() || di < dq.size()) begin
      g = (ia < da) ? ia : da;
      if (g < free) g = free;
      win_d = (ia <= g && da <= g) ? !last_d : (da <= g);
      last_d = win_d;
      t   = win_d ? dq[di] : iq[ii];
      arr = win_d ? da : ia;
      idx = t.addr[9:2];
      for (int c = arr; c <= g + 3; c++) begin
        if (win_d) begin
          dr_dreq[c] = 1; dr_dwe[c] = t.we; dr_daddr[c] = t.addr;
          dr_dwdata[c] = t.wdata; dr_dmask[c] = t.mask;
        end else begin
          dr_ireq[c] = 1; dr_iaddr[c] = t.addr;
        end
      end
      ex_iss[g+1] = 1;
      ex_mf[g+1] = win_d ? {t.we, t.mask, idx, t.wdata} : {1'b0, 4'hF, idx, 32'h0};
      if (win_d && t.we) begin
        for (int b = 0; b < 4; b++)
          if (t.mask[b]) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
      end else begin
        rd = ref_mem[idx];
        if (win_d) begin ex_dupd[g+3] = 1; ex_dval[g+3] = rd; end
        else       begin ex_iupd[g+3] = 1; ex_ival[g+3] = rd; end
      end
      if (win_d) ex_ddone[g+3] = 1; else ex_idone[g+3] = 1;
      free = g + 4;
      last_cycle = g + 3;
      if (win_d) begin
        di++;
        da = (di < dq.size()) ? g + 4 + dq[di].gap : INF;
      end else begin
        ii++;
        ia = (ii < iq.size()) ? g + 4 + iq[ii].gap : INF;
      end
    end
  endtask

  // Starts just after a rising edge with the arbiter idle; cycle c is sampled then driven.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      ob_idone[c] = i_done; ob_ddone[c] = d_done; ob_mreq[c] = mem_request;
      ob_irdata[c] = i_rdata; ob_drdata[c] = d_rdata;
      ob_mf[c] = {mem_we_re, mem_mask, mem_address, mem_data_in};
      i_req = dr_ireq[c]; i_addr = dr_iaddr[c];
      d_req = dr_dreq[c]; d_we = dr_dwe[c]; d_addr = dr_daddr[c];
      d_wdata = dr_dwdata[c]; d_mask = dr_dmask[c];
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_mask = '0;
    iq.delete(); dq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_we = 1'b1; pl_idx = idx; pl_data = val; ref_mem[idx] = val;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic tx_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input logic [3:0] m, input int gap);
    tx_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.mask = m; t.gap = gap;
    return t;
  endfunction

  task automatic test_reset();
    hold_reset();
    n_checks++;
    if ({i_done, d_done, mem_request, mem_we_re} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {i_done, d_done, mem_request, mem_we_re});
    end
    n_checks++;
    if ({i_rdata, d_rdata, mem_data_in, mem_address, mem_mask} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h %h %h %h %h exp=0", i_rdata, d_rdata, mem_data_in, mem_address, mem_mask);
    end
    release_reset();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({i_done, d_done, mem_request} !== 3'b0) begin
        n_fail++; $display("FAIL reset_idle c=%0d got=%b exp=000", c, {i_done, d_done, mem_request});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch();
    int np;
    hold_reset();
    preload(8'd4, 32'hDEADBEEF);
    iq.push_back(mk(32'h10, 1'b0, '0, '0, 0));
    build_schedule();
    release_reset();
    run_cycles(8);
    n_checks++;
    if ({ob_mreq[0], ob_mreq[1], ob_mreq[2]} !== 3'b010) begin
      n_fail++; $display("FAIL fetch_strobe got=%b exp=010", {ob_mreq[0], ob_mreq[1], ob_mreq[2]});
    end
    n_checks++;
    if (ob_mf[1] !== {1'b0, 4'hF, 8'd4, 32'h0}) begin
      n_fail++; $display("FAIL fetch_issue got=%h exp=%h", ob_mf[1], {1'b0, 4'hF, 8'd4, 32'h0});
    end
    np = 0;
    for (int c = 0; c < 8; c++) np += int'(ob_idone[c]) + int'(ob_ddone[c]);
    n_checks++;
    if (ob_idone[3] !== 1'b1 || np != 1) begin
      n_fail++; $display("FAIL fetch_done got=%0d pulses=%0d exp=1 pulses=1", ob_idone[3], np);
    end
    n_checks++;
    if (ob_irdata[3] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch_rdata got=%h exp=deadbeef", ob_irdata[3]);
    end
    n_checks++;
    if (ob_drdata[7] !== 32'h0) begin
      n_fail++; $display("FAIL fetch_drdata_kept got=%h exp=0", ob_drdata[7]);
    end
  endtask

  task automatic test_store_load();
    int np;
    hold_reset();
    preload(8'd8, 32'hAABBCCDD);
    dq.push_back(mk(32'h20, 1'b1, 32'h11223344, 4'b0101, 0));
    dq.push_back(mk(32'h20, 1'b0, 32'h0, 4'hF, 0));
    build_schedule();
    release_reset();
    run_cycles(10);
    n_checks++;
    if (ob_mf[1] !== {1'b1, 4'b0101, 8'd8, 32'h11223344}) begin
      n_fail++; $display("FAIL store_issue got=%h exp=%h", ob_mf[1], {1'b1, 4'b0101, 8'd8, 32'h11223344});
    end
    np = 0;
    for (int c = 0; c < 10; c++) np += int'(ob_ddone[c]) + int'(ob_idone[c]);
    n_checks++;
    if (ob_ddone[3] !== 1'b1 || ob_ddone[7] !== 1'b1 || np != 2) begin
      n_fail++; $display("FAIL store_load_done got=%0d%0d pulses=%0d exp=11 pulses=2", ob_ddone[3], ob_ddone[7], np);
    end
    n_checks++;
    if (ob_drdata[7] !== 32'hAA22CC44 || ob_drdata[6] !== 32'h0) begin
      n_fail++; $display("FAIL load_rdata got=%h prev=%h exp=aa22cc44 prev=0", ob_drdata[7], ob_drdata[6]);
    end
    n_checks++;
    if (ob_irdata[9] !== 32'h0) begin
      n_fail++; $display("FAIL load_irdata_kept got=%h exp=0", ob_irdata[9]);
    end
    n_checks++;
    if (tb_mem[8] !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL store_mem got=%h exp=aa22cc44", tb_mem[8]);
    end
  endtask

  task automatic test_contention();
    int ni, nd, nb;
    hold_reset();
    iq.push_back(mk(32'h100, 1'b0, '0, '0, 0));
    iq.push_back(mk(32'h104, 1'b0, '0, '0, 0));
    dq.push_back(mk(32'h200, 1'b0, '0, 4'hF, 0));
    dq.push_back(mk(32'h204, 1'b0, '0, 4'hF, 0));
    build_schedule();
    release_reset();
    run_cycles(18);
    ni = 0; nd = 0; nb = 0;
    for (int c = 0; c < 18; c++) begin
      ni += int'(ob_idone[c]); nd += int'(ob_ddone[c]);
      nb += int'(ob_idone[c] && ob_ddone[c]);
    end
    n_checks++;
    if ({ob_idone[3], ob_ddone[7], ob_idone[11], ob_ddone[15]} !== 4'b1111 || ni != 2 || nd != 2 || nb != 0) begin
      n_fail++; $display("FAIL rr_order got=%b i=%0d d=%0d both=%0d exp=1111 i=2 d=2 both=0",
                         {ob_idone[3], ob_ddone[7], ob_idone[11], ob_ddone[15]}, ni, nd, nb);
    end
    n_checks++;
    if ({ob_mf[1][39:32], ob_mf[5][39:32], ob_mf[9][39:32], ob_mf[13][39:32]} !== 32'h40804181) begin
      n_fail++; $display("FAIL rr_addr got=%h exp=40804181",
                         {ob_mf[1][39:32], ob_mf[5][39:32], ob_mf[9][39:32], ob_mf[13][39:32]});
    end
  endtask

  task automatic test_back_to_back();
    int ni, nd;
    hold_reset();
    for (int k = 0; k < 3; k++) dq.push_back(mk(32'h40 + 32'(4*k), 1'b1, 32'h0, 4'h0, 0));
    iq.push_back(mk(32'h80, 1'b0, '0, '0, 5));
    build_schedule();
    release_reset();
    run_cycles(18);
    ni = 0; nd = 0;
    for (int c = 0; c < 18; c++) begin ni += int'(ob_idone[c]); nd += int'(ob_ddone[c]); end
    n_checks++;
    if ({ob_ddone[3], ob_ddone[7], ob_idone[11], ob_ddone[15]} !== 4'b1111 || ni != 1 || nd != 3) begin
      n_fail++; $display("FAIL b2b_order got=%b i=%0d d=%0d exp=1111 i=1 d=3",
                         {ob_ddone[3], ob_ddone[7], ob_idone[11], ob_ddone[15]}, ni, nd);
    end
  endtask

  task automatic test_reset_mid();
    int np;
    hold_reset();
    preload(8'd3, 32'h12345678);
    dq.push_back(mk(32'hC, 1'b0, '0, 4'hF, 0));
    build_schedule();
    release_reset();
    run_cycles(5);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'hCAFEF00D; d_mask = 4'hF;
    @(posedge clk); #1;
    n_checks++;
    if (mem_request !== 1'b1 || d_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL abort_pre got=%0d %h exp=1 12345678", mem_request, d_rdata);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({i_done, d_done, mem_request, mem_we_re, mem_mask, mem_address, mem_data_in, i_rdata, d_rdata} !== '0) begin
      n_fail++; $display("FAIL abort_outputs got=%0d%0d%0d%0d %h %h %h %h %h exp=all0", i_done, d_done,
                         mem_request, mem_we_re, mem_mask, mem_address, mem_data_in, i_rdata, d_rdata);
    end
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    np = 0;
    for (int c = 0; c < 4; c++) begin
      np += int'(d_done) + int'(mem_request);
      @(posedge clk); #1;
    end
    n_checks++;
    if (np != 0) begin
      n_fail++; $display("FAIL abort_no_done got=%0d exp=0", np);
    end
    dq.delete();
    dq.push_back(mk(32'hC, 1'b1, 32'hCAFEF00D, 4'hF, 0));
    build_schedule();
    run_cycles(6);
    np = 0;
    for (int c = 0; c < 6; c++) np += int'(ob_ddone[c]);
    n_checks++;
    if (ob_ddone[3] !== 1'b1 || np != 1 || tb_mem[3] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL abort_reissue got=%0d pulses=%0d mem=%h exp=1 pulses=1 mem=cafef00d",
                         ob_ddone[3], np, tb_mem[3]);
    end
  endtask

  task automatic test_random();
    logic [31:0] cur_i, cur_d;
    logic [MFW-1:0] cur_mf;
    for (int it = 0; it < 3; it++) begin
      hold_reset();
      for (int k = 0; k < 16; k++) preload(8'(k), $urandom());
      for (int k = 0; k < 12; k++) begin
        tx_t t;
        t.addr  = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
        t.wdata = $urandom(); t.mask = 4'($urandom()); t.we = 1'($urandom());
        t.gap   = int'($urandom_range(0, 6));
        dq.push_back(t);
        t.addr  = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
        t.gap   = int'($urandom_range(0, 6));
        iq.push_back(t);
      end
      build_schedule();
      release_reset();
      run_cycles(last_cycle + 6);
      cur_i = '0; cur_d = '0; cur_mf = '0;
      for (int c = 0; c < last_cycle + 6; c++) begin
        if (ex_iupd[c]) cur_i = ex_ival[c];
        if (ex_dupd[c]) cur_d = ex_dval[c];
        if (ex_iss[c])  cur_mf = ex_mf[c];
        n_checks++;
        if ({ob_idone[c], ob_ddone[c], ob_mreq[c]} !== {ex_idone[c], ex_ddone[c], ex_iss[c]}) begin
          n_fail++; $display("FAIL rnd_ctrl it=%0d c=%0d got=%b exp=%b", it, c,
                             {ob_idone[c], ob_ddone[c], ob_mreq[c]}, {ex_idone[c], ex_ddone[c], ex_iss[c]});
        end
        n_checks++;
        if (ob_irdata[c] !== cur_i || ob_drdata[c] !== cur_d) begin
          n_fail++; $display("FAIL rnd_rdata it=%0d c=%0d got=%h/%h exp=%h/%h", it, c,
                             ob_irdata[c], ob_drdata[c], cur_i, cur_d);
        end
        n_checks++;
        if (ob_mf[c] !== cur_mf) begin
          n_fail++; $display("FAIL rnd_memfields it=%0d c=%0d got=%h exp=%h", it, c, ob_mf[c], cur_mf);
        end
      end
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (tb_mem[k] !== ref_mem[k]) begin
          n_fail++; $display("FAIL rnd_mem it=%0d idx=%0d got=%h exp=%h", it, k, tb_mem[k], ref_mem[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
